// File: rtl/issue_sb_tracker.sv
// rtl/issue_sb_tracker.sv - in-order issue scoreboard with RAW lookup, write-back bypass and prefix commit
module issue_sb_tracker #(
    parameter int NR_ENTRIES      = 8,
    parameter int NR_WB_PORTS     = 4,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int NR_RS           = 3,
    parameter int REG_ADDR_SIZE   = 6,
    parameter int DATA_W          = 64,
    localparam int TID_W          = $clog2(NR_ENTRIES)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_i,
    input  logic                                          issue_valid_i,
    input  logic [REG_ADDR_SIZE-1:0]                      issue_rd_i,
    output logic                                          issue_ready_o,
    output logic [TID_W-1:0]                              issue_tid_o,
    input  logic [NR_WB_PORTS-1:0]                        wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TID_W-1:0]             wb_tid_i,
    input  logic [NR_WB_PORTS-1:0][DATA_W-1:0]            wb_data_i,
    input  logic [NR_RS-1:0][REG_ADDR_SIZE-1:0]           rs_addr_i,
    output logic [NR_RS-1:0]                              rs_busy_o,
    output logic [NR_RS-1:0]                              rs_fwd_valid_o,
    output logic [NR_RS-1:0][DATA_W-1:0]                  rs_fwd_data_o,
    output logic [NR_COMMIT_PORTS-1:0]                    commit_valid_o,
    output logic [NR_COMMIT_PORTS-1:0][REG_ADDR_SIZE-1:0] commit_rd_o,
    output logic [NR_COMMIT_PORTS-1:0][DATA_W-1:0]        commit_data_o,
    input  logic [NR_COMMIT_PORTS-1:0]                    commit_ack_i,
    output logic                                          sb_full_o,
    output logic                                          sb_empty_o
);

    localparam logic [TID_W:0] FULL_CNT = (TID_W+1)'(NR_ENTRIES);

    logic [NR_ENTRIES-1:0]                     valid_q, valid_d;
    logic [NR_ENTRIES-1:0]                     done_q, done_d;
    logic [NR_ENTRIES-1:0][REG_ADDR_SIZE-1:0]  rd_q, rd_d;
    logic [NR_ENTRIES-1:0][DATA_W-1:0]         data_q, data_d;
    logic [TID_W-1:0]                          issue_ptr_q, issue_ptr_d;
    logic [TID_W-1:0]                          commit_ptr_q, commit_ptr_d;
    logic [TID_W:0]                            count_q, count_d;

    logic                  issue_fire;
    logic [TID_W:0]        ack_cnt;
    logic [NR_RS-1:0]      rs_hit;
    logic [TID_W-1:0]      lk_idx;
    logic [TID_W-1:0]      hit_idx;
    logic                  byp_hit;
    logic [DATA_W-1:0]     byp_data;
    logic [TID_W-1:0]      cm_idx;
    logic                  cm_prev;

    assign issue_ready_o = (count_q < FULL_CNT);
    assign issue_tid_o   = issue_ptr_q;
    assign sb_full_o     = (count_q == FULL_CNT);
    assign sb_empty_o    = (count_q == '0);
    assign issue_fire    = issue_valid_i && issue_ready_o && !flush_i;

    always_comb begin
        valid_d      = valid_q;
        done_d       = done_q;
        rd_d         = rd_q;
        data_d       = data_q;
        issue_ptr_d  = issue_ptr_q;
        commit_ptr_d = commit_ptr_q;
        count_d      = count_q;
        ack_cnt      = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (commit_ack_i[i]) ack_cnt = ack_cnt + (TID_W+1)'(1);
        end
        if (flush_i) begin
            valid_d      = '0;
            done_d       = '0;
            issue_ptr_d  = '0;
            commit_ptr_d = '0;
            count_d      = '0;
        end else begin
            // Ascending port order lets the highest-index port win a collision.
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && valid_q[wb_tid_i[p]]) begin
                    done_d[wb_tid_i[p]] = 1'b1;
                    data_d[wb_tid_i[p]] = wb_data_i[p];
                end
            end
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (commit_ack_i[i]) begin
                    valid_d[commit_ptr_q + TID_W'(i)] = 1'b0;
                    done_d[commit_ptr_q + TID_W'(i)]  = 1'b0;
                end
            end
            if (issue_fire) begin
                valid_d[issue_ptr_q] = 1'b1;
                done_d[issue_ptr_q]  = 1'b0;
                rd_d[issue_ptr_q]    = issue_rd_i;
            end
            issue_ptr_d  = issue_ptr_q + TID_W'(issue_fire);
            commit_ptr_d = commit_ptr_q + ack_cnt[TID_W-1:0];
            count_d      = count_q + (TID_W+1)'(issue_fire) - ack_cnt;
        end
    end

    // Walk from the head so the last match seen is the youngest, independent of raw index.
    always_comb begin
        rs_hit         = '0;
        rs_busy_o      = '0;
        rs_fwd_valid_o = '0;
        rs_fwd_data_o  = '0;
        lk_idx         = '0;
        hit_idx        = '0;
        byp_hit        = 1'b0;
        byp_data       = '0;
        for (int r = 0; r < NR_RS; r++) begin
            hit_idx  = '0;
            byp_hit  = 1'b0;
            byp_data = '0;
            if (rs_addr_i[r] != '0) begin
                for (int k = 0; k < NR_ENTRIES; k++) begin
                    lk_idx = commit_ptr_q + TID_W'(k);
                    if (valid_q[lk_idx] && rd_q[lk_idx] == rs_addr_i[r]) begin
                        rs_hit[r] = 1'b1;
                        hit_idx   = lk_idx;
                    end
                end
            end
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && wb_tid_i[p] == hit_idx) begin
                    byp_hit  = 1'b1;
                    byp_data = wb_data_i[p];
                end
            end
            if (rs_hit[r]) begin
                if (done_q[hit_idx]) begin
                    rs_fwd_valid_o[r] = 1'b1;
                    rs_fwd_data_o[r]  = data_q[hit_idx];
                end else if (byp_hit) begin
                    rs_fwd_valid_o[r] = 1'b1;
                    rs_fwd_data_o[r]  = byp_data;
                end else begin
                    rs_busy_o[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        commit_valid_o = '0;
        commit_rd_o    = '0;
        commit_data_o  = '0;
        cm_idx         = '0;
        cm_prev        = 1'b1;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            cm_idx            = commit_ptr_q + TID_W'(i);
            commit_valid_o[i] = cm_prev && valid_q[cm_idx] && done_q[cm_idx];
            commit_rd_o[i]    = rd_q[cm_idx];
            commit_data_o[i]  = data_q[cm_idx];
            cm_prev           = commit_valid_o[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= '0;
            done_q       <= '0;
            rd_q         <= '0;
            data_q       <= '0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            done_q       <= done_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            issue_ptr_q  <= issue_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            count_q      <= count_d;
        end
    end

    for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_wb_chk
        for (genvar q = p + 1; q < NR_WB_PORTS; q++) begin : g_wb_pair
            a_wb_unique: assert property (@(posedge clk_i) disable iff (!rst_ni)
                !(wb_valid_i[p] && wb_valid_i[q] && wb_tid_i[p] == wb_tid_i[q]));
        end
    end

    for (genvar i = 0; i < NR_COMMIT_PORTS; i++) begin : g_ack_chk
        a_ack_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
            commit_ack_i[i] |-> commit_valid_o[i]);
        if (i > 0) begin : g_prefix
            a_ack_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni)
                commit_ack_i[i] |-> commit_ack_i[i-1]);
        end
    end

endmodule

// File: tb/tb_issue_sb_tracker.sv
// tb/tb_issue_sb_tracker.sv - directed self-checking bench for issue_sb_tracker
module tb_issue_sb_tracker;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            issue_valid_i;
    logic [5:0]      issue_rd_i;
    logic            issue_ready_o;
    logic [2:0]      issue_tid_o;
    logic [3:0]      wb_valid_i;
    logic [3:0][2:0] wb_tid_i;
    logic [3:0][63:0] wb_data_i;
    logic [2:0][5:0] rs_addr_i;
    logic [2:0]      rs_busy_o;
    logic [2:0]      rs_fwd_valid_o;
    logic [2:0][63:0] rs_fwd_data_o;
    logic [1:0]      commit_valid_o;
    logic [1:0][5:0] commit_rd_o;
    logic [1:0][63:0] commit_data_o;
    logic [1:0]      commit_ack_i;
    logic            sb_full_o;
    logic            sb_empty_o;

    int n_checks = 0;
    int n_errors = 0;

    issue_sb_tracker dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_rd_i     (issue_rd_i),
        .issue_ready_o  (issue_ready_o),
        .issue_tid_o    (issue_tid_o),
        .wb_valid_i     (wb_valid_i),
        .wb_tid_i       (wb_tid_i),
        .wb_data_i      (wb_data_i),
        .rs_addr_i      (rs_addr_i),
        .rs_busy_o      (rs_busy_o),
        .rs_fwd_valid_o (rs_fwd_valid_o),
        .rs_fwd_data_o  (rs_fwd_data_o),
        .commit_valid_o (commit_valid_o),
        .commit_rd_o    (commit_rd_o),
        .commit_data_o  (commit_data_o),
        .commit_ack_i   (commit_ack_i),
        .sb_full_o      (sb_full_o),
        .sb_empty_o     (sb_empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
    endtask

    task automatic issue(input logic [5:0] rd);
        issue_valid_i = 1'b1;
        issue_rd_i    = rd;
        tick();
        issue_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        issue_rd_i    = '0;
        wb_valid_i    = '0;
        wb_tid_i      = '0;
        wb_data_i     = '0;
        rs_addr_i     = '0;
        commit_ack_i  = '0;
        rs_addr_i[0]  = 6'd5;
        #12;
        check("rst_ready", issue_ready_o, 1);
        check("rst_tid", issue_tid_o, 0);
        check("rst_empty", sb_empty_o, 1);
        check("rst_full", sb_full_o, 0);
        check("rst_cv", commit_valid_o, 0);
        check("rst_busy", rs_busy_o, 0);
        check("rst_fwd", rs_fwd_valid_o, 0);
        check("rst_cdata", commit_data_o[0], 0);
        tick();
        rst_ni = 1'b1;
        tick();

        // fill and full
        for (int i = 0; i < 8; i++) begin
            check("fill_tid", issue_tid_o, i);
            check("fill_ready", issue_ready_o, 1);
            issue(6'(i + 1));
        end
        check("fill_full", sb_full_o, 1);
        check("fill_ready_lo", issue_ready_o, 0);
        issue(6'd40);
        check("fill_9th_full", sb_full_o, 1);
        check("fill_9th_tid", issue_tid_o, 0);
        rs_addr_i[0] = 6'd3;
        #1;
        check("fill_busy", rs_busy_o, 3'b001);
        rst_ni = 1'b0;
        #1;
        check("async_rst_empty", sb_empty_o, 1);
        check("async_rst_busy", rs_busy_o, 0);
        rst_ni = 1'b1;
        tick();

        // youngest match and bypass
        issue(6'd5);
        issue(6'd5);
        wb_valid_i[0] = 1'b1; wb_tid_i[0] = 3'd0; wb_data_i[0] = 64'hAA;
        tick();
        wb_valid_i = '0;
        rs_addr_i[0] = 6'd5; rs_addr_i[1] = 6'd5; rs_addr_i[2] = 6'd0;
        #1;
        check("young_busy", rs_busy_o, 3'b011);
        check("young_fwd", rs_fwd_valid_o, 3'b000);
        wb_valid_i[3] = 1'b1; wb_tid_i[3] = 3'd1; wb_data_i[3] = 64'hBB;
        #1;
        check("byp_fwd", rs_fwd_valid_o, 3'b011);
        check("byp_busy", rs_busy_o, 3'b000);
        check("byp_data", rs_fwd_data_o[0], 64'hBB);
        tick();
        wb_valid_i = '0;
        #1;
        check("stored_fwd", rs_fwd_valid_o, 3'b011);
        check("stored_data", rs_fwd_data_o[1], 64'hBB);
        check("young_cv", commit_valid_o, 2'b11);
        check("young_cd0", commit_data_o[0], 64'hAA);
        commit_ack_i = 2'b11;
        tick();
        commit_ack_i = '0;
        check("young_empty", sb_empty_o, 1);
        check("young_tid", issue_tid_o, 2);

        // in-order commit
        pulse_reset();
        rs_addr_i = '0;
        issue(6'd1);
        issue(6'd2);
        issue(6'd3);
        wb_valid_i = 4'b0110;
        wb_tid_i[1] = 3'd1; wb_data_i[1] = 64'h11;
        wb_tid_i[2] = 3'd2; wb_data_i[2] = 64'h22;
        tick();
        wb_valid_i = '0;
        check("ord_cv_none", commit_valid_o, 2'b00);
        wb_valid_i[0] = 1'b1; wb_tid_i[0] = 3'd0; wb_data_i[0] = 64'h10;
        #1;
        check("ord_cv_lat", commit_valid_o, 2'b00);
        tick();
        wb_valid_i = '0;
        check("ord_cv", commit_valid_o, 2'b11);
        check("ord_rd0", commit_rd_o[0], 1);
        check("ord_rd1", commit_rd_o[1], 2);
        check("ord_d0", commit_data_o[0], 64'h10);
        check("ord_d1", commit_data_o[1], 64'h11);
        commit_ack_i = 2'b11;
        tick();
        commit_ack_i = '0;
        check("ord_head_cv", commit_valid_o, 2'b01);
        check("ord_head_rd", commit_rd_o[0], 3);
        check("ord_head_d", commit_data_o[0], 64'h22);
        check("ord_cnt_empty", sb_empty_o, 0);
        check("ord_tid", issue_tid_o, 3);
        commit_ack_i = 2'b01;
        tick();
        commit_ack_i = '0;
        check("ord_empty", sb_empty_o, 1);

        // wrap-around
        pulse_reset();
        for (int i = 0; i < 23; i++) begin
            check("wrap_tid", issue_tid_o, i % 8);
            issue(6'd9);
            wb_valid_i[0] = 1'b1; wb_tid_i[0] = 3'(i % 8); wb_data_i[0] = 64'(i + 100);
            tick();
            wb_valid_i = '0;
            check("wrap_cv", commit_valid_o, 2'b01);
            check("wrap_cd", commit_data_o[0], i + 100);
            commit_ack_i = 2'b01;
            tick();
            commit_ack_i = '0;
        end
        check("wrap_tid7", issue_tid_o, 7);
        issue(6'd7);
        issue(6'd7);
        wb_valid_i[0] = 1'b1; wb_tid_i[0] = 3'd7; wb_data_i[0] = 64'h77;
        tick();
        wb_valid_i = '0;
        rs_addr_i[0] = 6'd7;
        #1;
        check("wrap_busy", rs_busy_o, 3'b001);
        check("wrap_fwd_lo", rs_fwd_valid_o, 3'b000);
        wb_valid_i[2] = 1'b1; wb_tid_i[2] = 3'd0; wb_data_i[2] = 64'h70;
        #1;
        check("wrap_byp", rs_fwd_valid_o, 3'b001);
        check("wrap_byp_d", rs_fwd_data_o[0], 64'h70);
        tick();
        wb_valid_i = '0;
        check("wrap_st_d", rs_fwd_data_o[0], 64'h70);
        check("wrap_cv2", commit_valid_o, 2'b11);
        check("wrap_cd0", commit_data_o[0], 64'h77);
        check("wrap_cd1", commit_data_o[1], 64'h70);
        commit_ack_i = 2'b11;
        tick();
        commit_ack_i = '0;
        check("wrap_empty", sb_empty_o, 1);

        // simultaneous issue/commit/write-back at full
        pulse_reset();
        rs_addr_i = '0;
        for (int i = 0; i < 8; i++) issue(6'(i + 1));
        wb_valid_i[0] = 1'b1; wb_tid_i[0] = 3'd0; wb_data_i[0] = 64'h5A;
        tick();
        wb_valid_i = '0;
        commit_ack_i = 2'b01;
        issue_valid_i = 1'b1; issue_rd_i = 6'd20;
        wb_valid_i[1] = 1'b1; wb_tid_i[1] = 3'd3; wb_data_i[1] = 64'h33;
        #1;
        check("sim_ready_lo", issue_ready_o, 0);
        tick();
        commit_ack_i = '0;
        wb_valid_i = '0;
        issue_valid_i = 1'b0;
        check("sim_full_lo", sb_full_o, 0);
        check("sim_ready", issue_ready_o, 1);
        check("sim_tid", issue_tid_o, 0);
        issue(6'd20);
        check("sim_full", sb_full_o, 1);
        check("sim_tid1", issue_tid_o, 1);
        rs_addr_i[0] = 6'd4; rs_addr_i[1] = 6'd20;
        #1;
        check("sim_fwd", rs_fwd_valid_o, 3'b001);
        check("sim_fwd_d", rs_fwd_data_o[0], 64'h33);
        check("sim_busy", rs_busy_o, 3'b010);

        // flush
        pulse_reset();
        rs_addr_i = '0;
        for (int i = 0; i < 5; i++) issue(6'(i + 1));
        wb_valid_i[0] = 1'b1; wb_tid_i[0] = 3'd0; wb_data_i[0] = 64'h1;
        tick();
        wb_valid_i = '0;
        flush_i = 1'b1;
        issue_valid_i = 1'b1; issue_rd_i = 6'd6;
        commit_ack_i = 2'b01;
        rs_addr_i[0] = 6'd2; rs_addr_i[1] = 6'd3;
        #1;
        check("fl_cv_unmasked", commit_valid_o, 2'b01);
        check("fl_busy_unmasked", rs_busy_o, 3'b011);
        tick();
        flush_i = 1'b0;
        issue_valid_i = 1'b0;
        commit_ack_i = '0;
        check("fl_empty", sb_empty_o, 1);
        check("fl_tid", issue_tid_o, 0);
        check("fl_busy", rs_busy_o, 0);
        check("fl_cv", commit_valid_o, 0);
        wb_valid_i[0] = 1'b1; wb_tid_i[0] = 3'd1; wb_data_i[0] = 64'hDEAD;
        tick();
        wb_valid_i = '0;
        check("fl_stale_empty", sb_empty_o, 1);
        check("fl_stale_cv", commit_valid_o, 0);
        check("fl_stale_fwd", rs_fwd_valid_o, 0);
        issue(6'd0);
        rs_addr_i[0] = 6'd0;
        #1;
        check("rs0_busy", rs_busy_o, 0);
        check("rs0_fwd", rs_fwd_valid_o, 0);
        check("rs0_empty", sb_empty_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
